seven_seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit seven-segment display. One shared hex-to-seven-segment decoder serves every digit.
- Each digit is selected in turn for a programmable dwell time.
- Its BCD nibble and decimal point are presented to the shared decoder, and the matching digit-enable line is driven.
- An all-off guard interval is inserted between digits to suppress ghosting.
- Sits between the stopwatch BCD counters and the decoder/display pins; performs leading-zero suppression and tear-free frame snapshots.

---
 rtl/seven_seg_pkg.sv | 39 +++
 rtl/seven_seg_scan_ctrl_if.sv | 34 +++
 rtl/scan_timer.sv | 33 +++
 rtl/seven_seg_scan_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
// Shared types and helpers for the seven-segment scan controller.
//   scan_state_t : scan FSM states
//   BCD_W        : width of one BCD digit
//   MAX_DIGITS   : widest display the helper functions support
//   lz_mask()    : leading-zero suppression mask
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        SHOW
    } scan_state_t;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 16;

    // Bit k is set when digit k is a leading zero: it and every digit above it
    // are 0 with no decimal point requested. Digit 0 is never suppressed.
    // Only the low n bits are meaningful; callers slice what they need.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [BCD_W*MAX_DIGITS-1:0] digits,
        input logic [MAX_DIGITS-1:0]       dp,
        input int                          n
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  zero_above;
        mask       = '0;
        zero_above = 1'b1;
        for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
            if (k < n) begin
                zero_above = zero_above && (digits[k*BCD_W +: BCD_W] == '0) && !dp[k];
                mask[k]    = zero_above;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// seven_seg_scan_ctrl_if
// Bundle between the BCD counter side and the display side of the scan
// controller.
//   i_enable, i_lz_suppress, i_digits, i_dp : data/control into the controller
//   o_nibble, o_dp, o_seg_blank              : to the shared decoder
//   o_dig_en, o_frame_tick                   : digit enables and frame pulse
// master : the block feeding digits (drives i_*, observes o_*)
// slave  : the scan controller
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 6
);
    import seven_seg_pkg::*;

    logic                        i_enable;
    logic                        i_lz_suppress;
    logic [BCD_W*NUM_DIGITS-1:0] i_digits;
    logic [NUM_DIGITS-1:0]       i_dp;
    logic [BCD_W-1:0]            o_nibble;
    logic                        o_dp;
    logic                        o_seg_blank;
    logic [NUM_DIGITS-1:0]       o_dig_en;
    logic                        o_frame_tick;

    modport master (
        output i_enable, i_lz_suppress, i_digits, i_dp,
        input  o_nibble, o_dp, o_seg_blank, o_dig_en, o_frame_tick
    );

    modport slave (
        input  i_enable, i_lz_suppress, i_digits, i_dp,
        output o_nibble, o_dp, o_seg_blank, o_dig_en, o_frame_tick
    );

endinterface

// File: rtl/scan_timer.sv
// scan_timer
// Loadable down-counter timing the guard and dwell intervals.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load i_load_val this cycle (takes priority)
//   i_load_val     : interval length minus one
//   o_tc           : terminal count, high while the count is zero
// Loading N-1 makes o_tc rise in the N-th cycle after the load, so an owner
// that reloads on o_tc sees it as a single-cycle pulse.
module scan_timer #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign o_tc = (count == '0);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Time-multiplexed scan controller for a multi-digit seven-segment display
// sharing one decoder. Each digit gets an all-dark guard interval followed by
// a lit dwell interval; display data for a whole frame comes from a snapshot
// taken when the scan returns to digit 0.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : digits/dp/enable in, nibble/dp/blank/enables/tick out
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS           = 6,
    parameter int DWELL_CYCLES         = 50000,
    parameter int GUARD_CYCLES         = 500,
    parameter bit DIGIT_EN_ACTIVE_HIGH = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    seven_seg_scan_ctrl_if.slave  bus
);

    localparam int MAX_CYC = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      DWELL_LOAD  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]      GUARD_LOAD  = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    // With no guard interval each digit starts directly in SHOW.
    localparam scan_state_t           FIRST_STATE = (GUARD_CYCLES > 0) ? GUARD : SHOW;
    localparam logic [CNT_W-1:0]      FIRST_LOAD  = (GUARD_CYCLES > 0) ? GUARD_LOAD : DWELL_LOAD;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF     = DIGIT_EN_ACTIVE_HIGH ? {NUM_DIGITS{1'b0}}
                                                                         : {NUM_DIGITS{1'b1}};

    scan_state_t                 state, nxt_state;
    logic [IDX_W-1:0]            idx, nxt_idx;
    logic                        take_snap, tick_nxt, load, tc;
    logic [CNT_W-1:0]            load_val;

    logic [BCD_W*NUM_DIGITS-1:0] snap_digits, snap_digits_nxt;
    logic [NUM_DIGITS-1:0]       snap_dp, snap_dp_nxt;
    logic                        snap_lz, snap_lz_nxt;
    logic [MAX_DIGITS-1:0]       mask_wide;
    logic                        unused_mask_bits;

    logic [BCD_W-1:0]            nib_sel, nibble_nxt, nibble_q;
    logic                        dp_sel, sup_sel, dp_nxt, dp_q, blank_nxt, blank_q, tick_q;
    logic [NUM_DIGITS-1:0]       onehot, dig_en_nxt, dig_en_q;

    scan_timer #(.CNT_W(CNT_W)) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (load),
        .i_load_val (load_val),
        .o_tc       (tc)
    );

    // Next-state decision. Disable overrides any transition due this cycle.
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        take_snap = 1'b0;
        tick_nxt  = 1'b0;
        load      = 1'b0;
        load_val  = '0;
        if (!bus.i_enable) begin
            nxt_state = IDLE;
            nxt_idx   = '0;
            load      = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    nxt_state = FIRST_STATE;
                    nxt_idx   = '0;
                    take_snap = 1'b1;
                    load      = 1'b1;
                    load_val  = FIRST_LOAD;
                end
                GUARD: begin
                    if (tc) begin
                        nxt_state = SHOW;
                        load      = 1'b1;
                        load_val  = DWELL_LOAD;
                    end
                end
                SHOW: begin
                    if (tc) begin
                        nxt_state = FIRST_STATE;
                        load      = 1'b1;
                        load_val  = FIRST_LOAD;
                        if (idx == LAST_IDX) begin
                            nxt_idx   = '0;
                            take_snap = 1'b1;
                            tick_nxt  = 1'b1;
                        end else begin
                            nxt_idx = idx + 1'b1;
                        end
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    nxt_idx   = '0;
                    load      = 1'b1;
                end
            endcase
        end
    end

    // The snapshot being taken this cycle must already drive the registered
    // outputs of the first digit, so outputs look at the post-capture values.
    assign snap_digits_nxt  = take_snap ? bus.i_digits      : snap_digits;
    assign snap_dp_nxt      = take_snap ? bus.i_dp          : snap_dp;
    assign snap_lz_nxt      = take_snap ? bus.i_lz_suppress : snap_lz;
    assign mask_wide        = snap_lz_nxt ? lz_mask((BCD_W*MAX_DIGITS)'(snap_digits_nxt),
                                                    MAX_DIGITS'(snap_dp_nxt), NUM_DIGITS)
                                          : '0;
    assign unused_mask_bits = ^mask_wide;

    always_ff @(posedge i_clk) begin
        if (take_snap) begin
            snap_digits <= bus.i_digits;
            snap_dp     <= bus.i_dp;
            snap_lz     <= bus.i_lz_suppress;
        end
    end

    // Output values for the state being entered.
    always_comb begin
        nib_sel = '0;
        dp_sel  = 1'b0;
        sup_sel = 1'b0;
        onehot  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (nxt_idx == IDX_W'(k)) begin
                nib_sel   = snap_digits_nxt[k*BCD_W +: BCD_W];
                dp_sel    = snap_dp_nxt[k];
                sup_sel   = mask_wide[k];
                onehot[k] = 1'b1;
            end
        end
        nibble_nxt = '0;
        dp_nxt     = 1'b0;
        blank_nxt  = 1'b1;
        dig_en_nxt = DIG_OFF;
        case (nxt_state)
            GUARD: begin
                nibble_nxt = nib_sel;
                dp_nxt     = dp_sel;
            end
            SHOW: begin
                nibble_nxt = nib_sel;
                dp_nxt     = dp_sel;
                if (!sup_sel) begin
                    blank_nxt  = 1'b0;
                    dig_en_nxt = DIGIT_EN_ACTIVE_HIGH ? onehot : ~onehot;
                end
            end
            default: ;
        endcase
    end

    // ---- registered state and outputs ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            nibble_q <= '0;
            dp_q     <= 1'b0;
            blank_q  <= 1'b1;
            dig_en_q <= DIG_OFF;
            tick_q   <= 1'b0;
        end else begin
            state    <= nxt_state;
            idx      <= nxt_idx;
            nibble_q <= nibble_nxt;
            dp_q     <= dp_nxt;
            blank_q  <= blank_nxt;
            dig_en_q <= dig_en_nxt;
            tick_q   <= tick_nxt;
        end
    end

    assign bus.o_nibble     = nibble_q;
    assign bus.o_dp         = dp_q;
    assign bus.o_seg_blank  = blank_q;
    assign bus.o_dig_en     = dig_en_q;
    assign bus.o_frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl
// Bench for seven_seg_scan_ctrl. dut1: 4 digits, dwell 4, guard 1, active-high
// enables. dut2: 4 digits, dwell 4, no guard, active-low enables.
module tb_seven_seg_scan_ctrl;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst1_n, rst2_n;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus1 ();
    seven_seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus2 ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(N), .DWELL_CYCLES(4), .GUARD_CYCLES(1), .DIGIT_EN_ACTIVE_HIGH(1'b1)
    ) dut1 (
        .i_clk(clk), .i_rst_n(rst1_n), .bus(bus1.slave)
    );

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(N), .DWELL_CYCLES(4), .GUARD_CYCLES(0), .DIGIT_EN_ACTIVE_HIGH(1'b0)
    ) dut2 (
        .i_clk(clk), .i_rst_n(rst2_n), .bus(bus2.slave)
    );

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] nib;
        logic       dp;
        logic       blank;
        logic       tick;
    } obs_t;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic        lz;
        logic [3:0]  lit;
        string       name;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    obs_t q1[$];
    obs_t q2[$];
    vec_t vecs[9];

    localparam obs_t RST1 = '{en: 4'h0, nib: 4'h0, dp: 1'b0, blank: 1'b1, tick: 1'b0};
    localparam obs_t RST2 = '{en: 4'hF, nib: 4'h0, dp: 1'b0, blank: 1'b1, tick: 1'b0};

    function automatic obs_t sample(input int which);
        if (which == 1)
            return {bus1.o_dig_en, bus1.o_nibble, bus1.o_dp, bus1.o_seg_blank, bus1.o_frame_tick};
        return {bus2.o_dig_en, bus2.o_nibble, bus2.o_dp, bus2.o_seg_blank, bus2.o_frame_tick};
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got en=%b nib=%h dp=%b blank=%b tick=%b, expected en=%b nib=%h dp=%b blank=%b tick=%b",
                     name, act.en, act.nib, act.dp, act.blank, act.tick,
                     exp.en, exp.nib, exp.dp, exp.blank, exp.tick);
        end
    endtask

    // Push the first ncyc expected cycles of a frame starting at digit 0.
    task automatic push_frame(input int which, input logic [15:0] digits, input logic [3:0] dp,
                              input logic [3:0] lit, input logic first_tick, input int ncyc);
        int         guard;
        int         pushed;
        logic [3:0] off;
        obs_t       r;
        guard  = (which == 1) ? 1 : 0;
        off    = (which == 1) ? 4'h0 : 4'hF;
        pushed = 0;
        for (int k = 0; k < N; k++) begin
            for (int c = 0; c < guard + 4; c++) begin
                if (pushed < ncyc) begin
                    r.nib  = digits[k*4 +: 4];
                    r.dp   = dp[k];
                    r.tick = first_tick && (k == 0) && (c == 0);
                    if (c < guard || !lit[k]) begin
                        r.en    = off;
                        r.blank = 1'b1;
                    end else begin
                        r.en    = (which == 1) ? (4'b0001 << k) : ~(4'b0001 << k);
                        r.blank = 1'b0;
                    end
                    if (which == 1) q1.push_back(r);
                    else            q2.push_back(r);
                    pushed++;
                end
            end
        end
    endtask

    task automatic push_idle(input int which);
        if (which == 1) q1.push_back(RST1);
        else            q2.push_back(RST2);
    endtask

    task automatic step(input int which, input string name);
        obs_t exp;
        @(posedge clk);
        #1;
        if ((which == 1 && q1.size() == 0) || (which == 2 && q2.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, nothing expected for this cycle", name);
        end else begin
            exp = (which == 1) ? q1.pop_front() : q2.pop_front();
            check_obs(name, sample(which), exp);
        end
    endtask

    task automatic drain(input int which, input int n, input string name);
        repeat (n) step(which, name);
    endtask

    task automatic set_in1(input logic [15:0] d, input logic [3:0] dp, input logic lz);
        bus1.i_digits      = d;
        bus1.i_dp          = dp;
        bus1.i_lz_suppress = lz;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h4321, 4'b0000, 1'b0, 4'b1111, "basic_scan"};
        vecs[1] = '{16'h0005, 4'b0000, 1'b1, 4'b0001, "lz_0005"};
        vecs[2] = '{16'h0005, 4'b0100, 1'b1, 4'b0111, "lz_0005_dp2"};
        vecs[3] = '{16'h0000, 4'b0000, 1'b1, 4'b0001, "lz_all_zero"};
        vecs[4] = '{16'h0000, 4'b0000, 1'b0, 4'b1111, "no_lz_zero"};
        vecs[5] = '{16'h00FA, 4'b0000, 1'b1, 4'b0011, "lz_hex_passthru"};
        vecs[6] = '{16'h0A00, 4'b1000, 1'b1, 4'b1111, "lz_dp_top"};
        vecs[7] = '{16'h0300, 4'b0001, 1'b1, 4'b0111, "lz_dp_low"};
        vecs[8] = '{16'h1000, 4'b0000, 1'b1, 4'b1111, "lz_inner_zero"};

        rst1_n = 1'b0;
        rst2_n = 1'b0;
        bus1.i_enable = 1'b0;
        bus2.i_enable = 1'b0;
        set_in1(16'h0, 4'h0, 1'b0);
        bus2.i_digits      = 16'h0;
        bus2.i_dp          = 4'h0;
        bus2.i_lz_suppress = 1'b0;

        #12;
        check_obs("reset1", sample(1), RST1);
        check_obs("reset2", sample(2), RST2);
        @(posedge clk);
        #1;
        rst1_n = 1'b1;
        rst2_n = 1'b1;
        @(posedge clk);
        #1;
        check_obs("idle1", sample(1), RST1);

        // Table-driven frames: one full frame, the wrap cycle, then disable.
        for (int i = 0; i < 9; i++) begin
            set_in1(vecs[i].digits, vecs[i].dp, vecs[i].lz);
            bus1.i_enable = 1'b1;
            push_frame(1, vecs[i].digits, vecs[i].dp, vecs[i].lit, 1'b0, 20);
            push_frame(1, vecs[i].digits, vecs[i].dp, vecs[i].lit, 1'b1, 1);
            drain(1, 21, vecs[i].name);
            bus1.i_enable = 1'b0;
            push_idle(1);
            step(1, {vecs[i].name, "_off"});
        end

        // Mid-frame input change is invisible until the next snapshot.
        set_in1(16'h1111, 4'h0, 1'b0);
        bus1.i_enable = 1'b1;
        push_frame(1, 16'h1111, 4'h0, 4'hF, 1'b0, 20);
        push_frame(1, 16'h2222, 4'h0, 4'hF, 1'b1, 20);
        for (int s = 1; s <= 40; s++) begin
            step(1, "snapshot");
            if (s == 8) bus1.i_digits = 16'h2222;
        end
        bus1.i_enable = 1'b0;
        push_idle(1);
        step(1, "snapshot_off");

        // Disable during SHOW of digit 2, then re-enable.
        set_in1(16'h4321, 4'h0, 1'b0);
        bus1.i_enable = 1'b1;
        push_frame(1, 16'h4321, 4'h0, 4'hF, 1'b0, 13);
        drain(1, 13, "pre_disable");
        bus1.i_enable = 1'b0;
        push_idle(1);
        step(1, "disable_mid_dwell");
        bus1.i_enable = 1'b1;
        push_frame(1, 16'h4321, 4'h0, 4'hF, 1'b0, 6);
        drain(1, 6, "reenable");
        bus1.i_enable = 1'b0;
        push_idle(1);
        step(1, "reenable_off");

        // Disable on the wrap cycle: no frame tick, straight to IDLE.
        bus1.i_enable = 1'b1;
        push_frame(1, 16'h4321, 4'h0, 4'hF, 1'b0, 20);
        drain(1, 20, "pre_overlap");
        bus1.i_enable = 1'b0;
        push_idle(1);
        step(1, "overlap_disable_wins");

        // Asynchronous reset between clock edges during SHOW.
        bus1.i_enable = 1'b1;
        push_frame(1, 16'h4321, 4'h0, 4'hF, 1'b0, 4);
        drain(1, 4, "pre_async");
        #3;
        rst1_n = 1'b0;
        #1;
        check_obs("async_reset", sample(1), RST1);
        bus1.i_enable = 1'b0;
        @(posedge clk);
        #1;
        rst1_n = 1'b1;
        @(posedge clk);
        #1;
        check_obs("after_async", sample(1), RST1);

        // Active-low enables with no guard state.
        bus2.i_digits      = 16'h4321;
        bus2.i_dp          = 4'h0;
        bus2.i_lz_suppress = 1'b0;
        bus2.i_enable      = 1'b1;
        push_frame(2, 16'h4321, 4'h0, 4'hF, 1'b0, 16);
        push_frame(2, 16'h4321, 4'h0, 4'hF, 1'b1, 16);
        drain(2, 32, "noguard_low");
        bus2.i_enable = 1'b0;
        push_idle(2);
        step(2, "noguard_off");

        bus2.i_digits      = 16'h0005;
        bus2.i_lz_suppress = 1'b1;
        bus2.i_enable      = 1'b1;
        push_frame(2, 16'h0005, 4'h0, 4'b0001, 1'b0, 16);
        push_frame(2, 16'h0005, 4'h0, 4'b0001, 1'b1, 1);
        drain(2, 17, "noguard_lz");
        bus2.i_enable = 1'b0;
        push_idle(2);
        step(2, "noguard_lz_off");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
